// File: rtl/fwd_hazard_unit.sv
// fwd_hazard_unit: shadow-pipeline forwarding selects and load-use stall for EX/M1..Mn/WB
module fwd_hazard_unit #(
    parameter int REG_AW   = 5,
    parameter int NUM_SRC  = 2,
    parameter int LOAD_LAT = 1,
    parameter int CNT_W    = 16,
    localparam int SELW    = $clog2(LOAD_LAT + 2)
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      id_valid,
    input  logic [NUM_SRC*REG_AW-1:0] id_src,
    input  logic [NUM_SRC-1:0]        id_src_used,
    input  logic                      id_wr_en,
    input  logic [REG_AW-1:0]         id_wr_reg,
    input  logic                      id_is_load,
    input  logic                      flush,
    output logic                      stall,
    output logic [NUM_SRC*SELW-1:0]   fwd_sel,
    output logic [CNT_W-1:0]          stall_cnt
);
    localparam int NST = LOAD_LAT + 2;

    logic [NST-1:0]    s_valid, s_wr, s_load;
    logic [REG_AW-1:0] s_reg [NST];
    logic [REG_AW-1:0] ex_src [NUM_SRC];
    logic [NUM_SRC-1:0] ex_used;

    // ID stalls while any operand depends on a load whose data is not yet in WB
    always_comb begin
        stall = 1'b0;
        for (int i = 0; i < NUM_SRC; i++)
            for (int s = 0; s < LOAD_LAT; s++)
                if (id_src_used[i] && s_valid[s] && s_wr[s] && s_load[s] &&
                    s_reg[s] == id_src[i*REG_AW +: REG_AW] && id_src[i*REG_AW +: REG_AW] != '0)
                    stall = 1'b1;
        if (!id_valid || flush)
            stall = 1'b0;
    end

    // Scan oldest to youngest so the youngest usable writer overrides; loads before WB are skipped
    always_comb begin
        fwd_sel = '0;
        for (int i = 0; i < NUM_SRC; i++)
            for (int k = LOAD_LAT + 1; k >= 1; k--)
                if (s_valid[0] && ex_used[i] && s_valid[k] && s_wr[k] &&
                    s_reg[k] == ex_src[i] && ex_src[i] != '0 && !(s_load[k] && k <= LOAD_LAT))
                    fwd_sel[i*SELW +: SELW] = SELW'(k);
    end

    // Shadow pipeline advances every edge; EX gets a bubble on stall or flush
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s_valid <= '0;
            s_wr    <= '0;
            s_load  <= '0;
            ex_used <= '0;
            for (int s = 0; s < NST; s++)
                s_reg[s] <= '0;
            for (int i = 0; i < NUM_SRC; i++)
                ex_src[i] <= '0;
        end else begin
            for (int k = 1; k < NST; k++) begin
                s_valid[k] <= s_valid[k-1];
                s_wr[k]    <= s_wr[k-1];
                s_load[k]  <= s_load[k-1];
                s_reg[k]   <= s_reg[k-1];
            end
            s_valid[0] <= id_valid && !stall && !flush;
            s_wr[0]    <= id_wr_en;
            s_load[0]  <= id_is_load;
            s_reg[0]   <= id_wr_reg;
            ex_used    <= id_src_used;
            for (int i = 0; i < NUM_SRC; i++)
                ex_src[i] <= id_src[i*REG_AW +: REG_AW];
        end
    end

    // Saturating count of stalled cycles
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            stall_cnt <= '0;
        else if (stall && stall_cnt != '1)
            stall_cnt <= stall_cnt + 1'b1;
    end
endmodule

// File: doc/fwd_hazard_unit.md
Name: fwd_hazard_unit

Overview:
- Parametrised forwarding and load-use hazard controller for the pipelined CPU.
- Keeps its own shadow pipeline of destination registers (EX, M1..M(LOAD_LAT), WB), fed from the ID stage.
- Generates per-operand bypass selects for EX, plus the ID stall.
- Supports N source operands and multi-cycle memory.

Parameters:
- REG_AW, 5, register address width.
- NUM_SRC, 2, number of source operands per instruction.
- LOAD_LAT, 1, number of memory stages M1..M(LOAD_LAT); must be ≥1. Load data is valid only in WB.
- CNT_W, 16, width of the stall performance counter.
- SELW (localparam), clog2(LOAD_LAT+2), width of each select field.

Ports:
- clk  in  1  pipeline clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- id_valid  in  1  ID holds a real instruction.
- id_src  in  NUM_SRC*REG_AW  ID source register numbers; operand i is in bits [i*REG_AW +: REG_AW].
- id_src_used  in  NUM_SRC  operand i is actually read.
- id_wr_en  in  1  ID instruction writes a register.
- id_wr_reg  in  REG_AW  ID destination register.
- id_is_load  in  1  ID instruction is a load.
- flush  in  1  squash the ID instruction (branch redirect).
- stall  out  1  hold PC/IF/ID this cycle.
- fwd_sel  out  NUM_SRC*SELW  per-operand bypass select for the EX instruction.
- stall_cnt  out  CNT_W  saturating count of stall cycles.

Behaviour:
Shadow stages and entry format
- Stage index: EX=0, Mk=k, WB=LOAD_LAT+1.
- Each stage holds {valid, wr_en, wr_reg, is_load}.
- EX additionally holds src[NUM_SRC] and used[NUM_SRC].

Reset (async, rst_n=0)
- All stage valid bits = 0; stall_cnt = 0.
- Outputs are therefore stall=0 and fwd_sel=0.
- Reset released mid-pipeline restarts empty; no partial entries survive.

Writer qualification
- A stage is a "writer of r" when valid && wr_en && wr_reg==r && r!=0.
- Register 0 is never forwarded and never causes a stall.

Stall (combinational)
- stall=1 when id_valid && !flush, and for some i: id_src_used[i] && a stage s in 0..LOAD_LAT-1 is a load writer of id_src[i].
- LOAD_LAT=1: only a load in EX stalls (classic one-cycle bubble).
- LOAD_LAT=3: a load in EX, M1 or M2 stalls, giving up to 3 consecutive stall cycles.
- A non-load writer never stalls.

Shadow advance (every rising edge, no external enable)
- Stages M1..WB take the previous stage's contents unconditionally. The entry leaving WB is dropped.
- EX takes the ID fields when id_valid && !stall && !flush; otherwise EX takes a bubble (valid=0).
- flush has priority over stall: a flushed ID instruction is never inserted, and stall is forced to 0 that cycle.
- Older stages are unaffected by flush.

Forwarding select (combinational from EX entry)
- fwd_sel[i] = k for the youngest stage k in 1..LOAD_LAT+1 that is a writer of EX.src[i], subject to the availability rule below.
- Availability rule: a load writer in M1..M(LOAD_LAT) is not a valid source. Search continues to older stages. The stall guarantees a load match can only be found in WB.
- No match, EX invalid, or !used[i] -> fwd_sel[i] = 0 (register file).
- Encoding for LOAD_LAT=1: 0=RF, 1=MEM, 2=WB. Priority is MEM over WB.
- The register file is write-first; no bypass beyond WB.

Counter
- stall_cnt increments by 1 on each edge where stall=1.
- It saturates at all-ones and never wraps.

Latency
- stall: 0 cycles from ID inputs.
- fwd_sel: valid in the cycle after the instruction is accepted into EX.

Test Plan:
1. ALU back-to-back, LOAD_LAT=1: add r3 then sub r4,r3,r3.
   Required: stall=0; next cycle fwd_sel op0=op1=1 (MEM).
2. Load-use, LOAD_LAT=1: lw r5 then add r6,r5,r0.
   Required: stall=1 for exactly 1 cycle; stall_cnt=1; a bubble enters EX; then fwd_sel op0=2 (WB), op1=0.
3. LOAD_LAT=3: lw r7 followed by a use of r7.
   Required: stall high 3 consecutive cycles, then fwd_sel=4 (WB).
   Variant: one independent instruction between the load and the use. Required: stall 2 cycles.
4. Double writer: add r2 (older), add r2 (younger), then use r2.
   Required: fwd_sel=1 (youngest wins), not WB.
   Variant: destination r0 with src r0. Required: fwd_sel=0, stall=0.
5. Flush during stall: load-use in progress, flush=1 in the stall cycle.
   Required: stall=0 that cycle; EX gets a bubble; the consumer never appears in EX; stall_cnt not incremented.
6. Reset mid-run: assert rst_n=0 asynchronously while the shadow is full.
   Required: stall=0, fwd_sel=0 and stall_cnt=0 immediately, without a clock edge.
   Saturation check: force CNT_W=4 and hold stall for 20 cycles. Required: stall_cnt stops at 15.
